// File: rtl/gshare_pht_ctrl_if.sv
// gshare_pht_ctrl_if: PHT RAM bus between the gshare controller and the
// 2-read/1-write pattern history table.
//   master : controller side (drives addresses and the write port)
//   slave  : RAM side (returns asynchronous read data)
interface gshare_pht_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] pht_raddr0;
    logic [ADDR_WIDTH-1:0] pht_raddr1;
    logic [DATA_WIDTH-1:0] pht_rdata0;
    logic [DATA_WIDTH-1:0] pht_rdata1;
    logic                  pht_we;
    logic [ADDR_WIDTH-1:0] pht_waddr;
    logic [DATA_WIDTH-1:0] pht_wdata;

    modport master (
        output pht_raddr0,
        output pht_raddr1,
        input  pht_rdata0,
        input  pht_rdata1,
        output pht_we,
        output pht_waddr,
        output pht_wdata
    );

    modport slave (
        input  pht_raddr0,
        input  pht_raddr1,
        output pht_rdata0,
        output pht_rdata1,
        input  pht_we,
        input  pht_waddr,
        input  pht_wdata
    );

endinterface

// File: rtl/gshare_pht_ctrl.sv
// gshare_pht_ctrl: gshare branch-predictor controller.
//   - Port 0 of the PHT serves fetch-time prediction (combinational).
//   - Port 1 serves execute-time read-modify-write of the saturating counters,
//     written back one cycle later through a registered write stage.
//   - Owns the speculative GHR and its recovery on mispredict.
// Optional feature macro: BP_UPDATE_BYPASS_EN
//   defined   : reads that hit the pending write-stage entry take its data,
//               so back-to-back same-index updates are exact.
//   undefined : reads see RAM contents only (a lost update is tolerated).
module gshare_pht_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int GHR_WIDTH  = 5,
    parameter int CTR_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,

    input  logic                 res_valid,
    input  logic [31:0]          res_pc,
    input  logic [GHR_WIDTH-1:0] res_ghr,
    input  logic                 res_taken,
    input  logic                 res_mispredict,

    gshare_pht_ctrl_if.master    pht
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [GHR_WIDTH-1:0]  ghr;
    logic [GHR_WIDTH-1:0]  ghr_next;

    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic [DATA_WIDTH-1:0] upd_data;

    // ------------------------------------------------------------------
    // Datapath signals
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fetch_pc_idx;
    logic [ADDR_WIDTH-1:0] res_pc_idx;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic [ADDR_WIDTH-1:0] res_idx;
    logic [CTR_WIDTH-1:0]  ctr0;
    logic [CTR_WIDTH-1:0]  ctr1;
    logic [CTR_WIDTH-1:0]  ctr_next;
    logic [DATA_WIDTH-1:0] upd_data_next;

    // Only the word-index bits of the PCs and the counter bits of the RAM
    // words take part in prediction; the rest are sunk here.
    logic unused_bits;
    assign unused_bits = ^{1'b0,
                           fetch_pc[31:ADDR_WIDTH+2], fetch_pc[1:0],
                           res_pc[31:ADDR_WIDTH+2],   res_pc[1:0],
                           pht.pht_rdata0[DATA_WIDTH-1:CTR_WIDTH],
                           pht.pht_rdata1[DATA_WIDTH-1:CTR_WIDTH]};

    assign fetch_pc_idx = fetch_pc[ADDR_WIDTH+1:2];
    assign res_pc_idx   = res_pc[ADDR_WIDTH+1:2];

    // gshare index: PC word index XOR zero-extended history
    function automatic logic [ADDR_WIDTH-1:0] pht_idx(
        input logic [ADDR_WIDTH-1:0] pc_idx,
        input logic [GHR_WIDTH-1:0]  g
    );
        logic [ADDR_WIDTH-1:0] g_ext;
        g_ext                = '0;
        g_ext[GHR_WIDTH-1:0] = g;
        return pc_idx ^ g_ext;
    endfunction

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------

    // Read port 0 address: parked at 0 when no lookup is requested
    always_comb begin
        fetch_idx = '0;
        if (fetch_valid) begin
            fetch_idx = pht_idx(fetch_pc_idx, ghr);
        end
    end

    // Fetch counter select, optionally forwarded from the write stage
    always_comb begin
        ctr0 = pht.pht_rdata0[CTR_WIDTH-1:0];
`ifdef BP_UPDATE_BYPASS_EN
        if (upd_valid && (fetch_idx == upd_addr)) begin
            ctr0 = upd_data[CTR_WIDTH-1:0];
        end
`endif
    end

    assign pred_taken     = fetch_valid & ctr0[CTR_WIDTH-1];
    assign pred_ghr       = ghr;
    assign pht.pht_raddr0 = fetch_idx;

    // ------------------------------------------------------------------
    // Resolve-side read-modify-write
    // ------------------------------------------------------------------

    // Read port 1 address: parked at 0 when nothing resolves
    always_comb begin
        res_idx = '0;
        if (res_valid) begin
            res_idx = pht_idx(res_pc_idx, res_ghr);
        end
    end

    assign pht.pht_raddr1 = res_idx;

    // Resolve counter select, optionally forwarded from the write stage
    always_comb begin
        ctr1 = pht.pht_rdata1[CTR_WIDTH-1:0];
`ifdef BP_UPDATE_BYPASS_EN
        if (res_valid && upd_valid && (res_idx == upd_addr)) begin
            ctr1 = upd_data[CTR_WIDTH-1:0];
        end
`endif
    end

    // Saturating increment/decrement of the resolved counter
    always_comb begin
        ctr_next = ctr1;
        if (res_taken) begin
            if (ctr1 != '1) begin
                ctr_next = ctr1 + 1'b1;
            end
        end else begin
            if (ctr1 != '0) begin
                ctr_next = ctr1 - 1'b1;
            end
        end
        upd_data_next                = '0;
        upd_data_next[CTR_WIDTH-1:0] = ctr_next;
    end

    // ------------------------------------------------------------------
    // Global history register
    // ------------------------------------------------------------------

    // Next GHR: mispredict recovery wins over the speculative fetch shift
    always_comb begin
        ghr_next = ghr;
        if (res_valid && res_mispredict) begin
            ghr_next = {res_ghr[GHR_WIDTH-2:0], res_taken};
        end else if (fetch_valid) begin
            ghr_next = {ghr[GHR_WIDTH-2:0], pred_taken};
        end
    end

    // GHR register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered write stage
    // ------------------------------------------------------------------

    // Capture one counter update per resolved branch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upd_valid <= 1'b0;
            upd_addr  <= '0;
            upd_data  <= '0;
        end else if (res_valid) begin
            upd_valid <= 1'b1;
            upd_addr  <= res_idx;
            upd_data  <= upd_data_next;
        end else begin
            upd_valid <= 1'b0;
        end
    end

    // Write enable is also masked by reset_n so that an update captured on
    // the edge before reset asserts never reaches the RAM.
    assign pht.pht_we    = upd_valid & reset_n;
    assign pht.pht_waddr = upd_addr;
    assign pht.pht_wdata = upd_data;

endmodule
